// File: rtl/rt_mem_loader.sv
// Streams source words into memory one write at a time, then optionally reads them
// back and compares a running sum of both passes before enabling instruction fetch.
module rt_mem_loader #(
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_STRIDE = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int TIMEOUT     = 1024,
  parameter int VERIFY      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    num_words_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [2:0]              mem_lim_funct_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rvalid_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    timeout_o,
  output logic                    fetch_enable_o,
  output logic [CNT_WIDTH-1:0]    words_done_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH, WREQ, WWAIT, WGAP, RREQ, RWAIT, RGAP, DONE, ERROR
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CNT_WIDTH-1:0]    num_q;
  logic [CNT_WIDTH-1:0]    rd_cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   wr_sum_q;
  logic [DATA_WIDTH-1:0]   rd_sum_q;
  logic [TW-1:0]           tmo_q;
  logic [GW-1:0]           gap_q;

  logic                    w_last;
  logic                    r_last;
  logic [DATA_WIDTH-1:0]   rd_sum_fin;

  // "Last word" is judged from the WAIT state (count not yet bumped) or the GAP state.
  always_comb begin
    w_last     = 1'b0;
    r_last     = 1'b0;
    rd_sum_fin = rd_sum_q;
    if (state_q == WGAP) w_last = (words_done_o == num_q);
    else                 w_last = ((words_done_o + CNT_WIDTH'(1)) == num_q);
    if (state_q == RGAP) begin
      r_last = (rd_cnt_q == num_q);
    end else begin
      r_last     = ((rd_cnt_q + CNT_WIDTH'(1)) == num_q);
      rd_sum_fin = rd_sum_q + mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      base_q         <= '0;
      num_q          <= '0;
      rd_cnt_q       <= '0;
      data_q         <= '0;
      wr_sum_q       <= '0;
      rd_sum_q       <= '0;
      tmo_q          <= '0;
      gap_q          <= '0;
      words_done_o   <= '0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      timeout_o      <= 1'b0;
      fetch_enable_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            base_q       <= base_addr_i;
            addr_q       <= base_addr_i;
            num_q        <= num_words_i;
            rd_cnt_q     <= '0;
            words_done_o <= '0;
            wr_sum_q     <= '0;
            rd_sum_q     <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            error_o      <= 1'b0;
            timeout_o    <= 1'b0;
            if (num_words_i == '0) begin
              state_q        <= DONE;
              done_o         <= 1'b1;
              fetch_enable_o <= 1'b1;
            end else begin
              state_q        <= FETCH;
              done_o         <= 1'b0;
              fetch_enable_o <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (s_valid_i) begin
            data_q   <= s_data_i;
            wr_sum_q <= wr_sum_q + s_data_i;
            state_q  <= WREQ;
          end
        end
        WREQ: begin
          tmo_q   <= '0;
          state_q <= WWAIT;
        end
        WWAIT, WGAP: begin
          if ((state_q == WWAIT) && !mem_rvalid_i) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
              state_q   <= ERROR;
              error_o   <= 1'b1;
              timeout_o <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end else if ((state_q == WWAIT) && (GAP_CYCLES != 0)) begin
            words_done_o <= words_done_o + CNT_WIDTH'(1);
            gap_q        <= '0;
            state_q      <= WGAP;
          end else if ((state_q == WGAP) && (gap_q != GW'(GAP_CYCLES - 1))) begin
            gap_q <= gap_q + GW'(1);
          end else begin
            // Gap finished (or skipped): move to the next word or into the verify pass.
            if (state_q == WWAIT) words_done_o <= words_done_o + CNT_WIDTH'(1);
            if (w_last) begin
              if (VERIFY != 0) begin
                addr_q  <= base_q;
                state_q <= RREQ;
              end else begin
                state_q        <= DONE;
                done_o         <= 1'b1;
                fetch_enable_o <= 1'b1;
              end
            end else begin
              addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
              state_q <= FETCH;
            end
          end
        end
        RREQ: begin
          tmo_q   <= '0;
          state_q <= RWAIT;
        end
        RWAIT, RGAP: begin
          if ((state_q == RWAIT) && !mem_rvalid_i) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
              state_q   <= ERROR;
              error_o   <= 1'b1;
              timeout_o <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end else if ((state_q == RWAIT) && (GAP_CYCLES != 0)) begin
            rd_sum_q <= rd_sum_fin;
            rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
            gap_q    <= '0;
            state_q  <= RGAP;
          end else if ((state_q == RGAP) && (gap_q != GW'(GAP_CYCLES - 1))) begin
            gap_q <= gap_q + GW'(1);
          end else begin
            if (state_q == RWAIT) begin
              rd_sum_q <= rd_sum_fin;
              rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
            end
            if (r_last) begin
              if (rd_sum_fin == wr_sum_q) begin
                state_q        <= DONE;
                done_o         <= 1'b1;
                fetch_enable_o <= 1'b1;
              end else begin
                state_q <= ERROR;
                error_o <= 1'b1;
              end
            end else begin
              addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
              state_q <= RREQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from the state flop so each request lasts exactly its state cycle.
  assign busy_o          = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign s_ready_o       = (state_q == FETCH);
  assign mem_en_o        = (state_q == WREQ) || (state_q == RREQ);
  assign mem_we_o        = (state_q == WREQ);
  assign mem_be_o        = (state_q == WREQ) ? '1 : '0;
  assign mem_wdata_o     = (state_q == WREQ) ? data_q : '0;
  assign mem_lim_funct_o = 3'b000;
  assign mem_addr_o      = (state_q == IDLE) ? '0 : addr_q;

endmodule

// File: doc/rt_mem_loader.md
RT_MEM_LOADER -- requirements
Module: rt_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width (multiple of 8).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, word-count width.
REQ-004 SHALL have parameter ADDR_STRIDE, default 4, byte increment per word.
REQ-005 SHALL have parameter GAP_CYCLES, default 1, idle cycles after each rvalid.
REQ-006 SHALL have parameter TIMEOUT, default 1024, max cycles awaiting rvalid.
REQ-007 SHALL have parameter VERIFY, default 1, enables readback checksum pass.
REQ-008 SHALL have ports clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-009 SHALL have ports start_i in 1, base_addr_i in ADDR_WIDTH, num_words_i in CNT_WIDTH.
REQ-010 SHALL have ports s_valid_i in 1, s_ready_o out 1, s_data_i in DATA_WIDTH (source word stream).
REQ-011 SHALL have ports mem_en_o out 1, mem_we_o out 1, mem_addr_o out ADDR_WIDTH, mem_wdata_o out DATA_WIDTH, mem_be_o out DATA_WIDTH/8, mem_lim_funct_o out 3, mem_rdata_i in DATA_WIDTH, mem_rvalid_i in 1.
REQ-012 SHALL have ports busy_o, done_o, error_o, timeout_o, fetch_enable_o out 1 each; words_done_o out CNT_WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, WREQ, WWAIT, WGAP, RREQ, RWAIT, RGAP, DONE, ERROR.
REQ-014 SHALL, in IDLE/DONE/ERROR on start_i=1, latch base_addr_i and num_words_i, clear counters, checksums, done_o, error_o, timeout_o, fetch_enable_o; go FETCH next cycle (DONE if num_words_i=0).
REQ-015 SHALL ignore start_i in all other states.
REQ-016 SHALL assert s_ready_o only in FETCH; on s_valid_i&s_ready_o capture s_data_i, add to write checksum (sum mod 2^DATA_WIDTH), go WREQ.
REQ-017 SHALL in WREQ drive mem_en_o=1, mem_we_o=1, mem_be_o all ones, mem_wdata_o=captured word for exactly one cycle, then WWAIT.
REQ-018 SHALL drive mem_lim_funct_o=0 always; mem_addr_o=current address in all non-idle states.
REQ-019 SHALL in WWAIT on mem_rvalid_i go WGAP, increment words_done_o; mem_rvalid_i outside *WAIT states ignored.
REQ-020 SHALL hold WGAP/RGAP for GAP_CYCLES cycles (0 = skip), then address += ADDR_STRIDE modulo 2^ADDR_WIDTH.
REQ-021 SHALL after last write go RREQ at base address if VERIFY=1, else DONE.
REQ-022 SHALL in RREQ drive mem_en_o=1, mem_we_o=0 one cycle; in RWAIT on rvalid add mem_rdata_i to read checksum.
REQ-023 SHALL after last read compare checksums: equal -> DONE, different -> ERROR with error_o=1.
REQ-024 SHALL count cycles in WWAIT/RWAIT; count reaching TIMEOUT -> ERROR, error_o=1, timeout_o=1.
REQ-025 SHALL assert busy_o in all states except IDLE, DONE, ERROR.
REQ-026 SHALL set done_o=1 and fetch_enable_o=1 in DONE, held until next start_i; fetch_enable_o never 1 after ERROR.
REQ-027 SHALL keep mem_en_o=0 in IDLE, FETCH, *WAIT, *GAP, DONE, ERROR.

Reset
REQ-028 SHALL on rst_n=0 asynchronously enter IDLE with all outputs 0, address and counters 0.
REQ-029 SHALL on reset mid-transfer abandon it; no further mem_en_o until a new start_i.

Verification
REQ-030 SHALL pass: base 0x000, num_words 4, stream 0x11,0x22,0x33,0x44, rvalid 2 cycles after each en -> writes at 0x0,0x4,0x8,0xC, reads same, done_o=1, fetch_enable_o=1, words_done_o=4.
REQ-031 SHALL pass: num_words 0 -> DONE one cycle after start, no mem_en_o pulse.
REQ-032 SHALL pass: rvalid withheld, TIMEOUT=16 -> ERROR 16 cycles into WWAIT, timeout_o=1, fetch_enable_o=0.
REQ-033 SHALL pass: readback word 2 corrupted by 1 -> error_o=1, timeout_o=0, done_o=0.
REQ-034 SHALL pass: base 0x3FFFFC, 2 words, ADDR_WIDTH 22 -> second address 0x000000.
REQ-035 SHALL pass: rst_n low in WWAIT of word 1, then start base 0x100 num 1 -> single write at 0x100, done_o=1.
